addsub_serial: RTL

Parametrised, digit-serial add/subtract unit computing `a + b` or `a - b` over `WIDTH` bits, `DIGIT` bits per clock. It replaces the fixed 4-bit combinational sum/difference unit. It adds a valid/ready handshake on both sides, plus carry/no-borrow, signed overflow and zero flags. It sits between an operand source and a result consumer in the arithmetic datapath.

---
 rtl/addsub_serial.sv | 80 ++++++++
 1 files changed

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial add/subtract with valid/ready handshake and carry/ovf/zero flags
// Ports: clk, rst_n (async active-low); in_valid/in_ready with operands a, b and sub (1 = a - b);
//        out_valid/out_ready with result s, cout (no-borrow when subtracting), ovf (signed), zero.
module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] ra, rb, acc, acc_nx;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [DIGIT:0] dsum;
  logic [CW-1:0] cnt;
  logic c, a_msb, b_msb, last;
  assign dsum = {1'b0, ra[DIGIT-1:0]} + {1'b0, rb[DIGIT-1:0]} + {{DIGIT{1'b0}}, c};
  // sum digits enter at the top so the LSB digit ends up at the bottom after NDIG shifts
  assign cat = {dsum[DIGIT-1:0], acc};
  assign acc_nx = cat[WIDTH+DIGIT-1:DIGIT];
  assign last = cnt == CW'(NDIG - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    state_nx = state == IDLE ? (in_valid ? CALC : IDLE) :
               state == CALC ? (last ? DONE : CALC) :
               (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ra <= '0;
      rb <= '0;
      acc <= '0;
      c <= 1'b0;
      cnt <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      s <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
      zero <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      ra <= a;
      rb <= b ^ {WIDTH{sub}};
      c <= sub;
      cnt <= '0;
      // operand sign bits are shifted away during CALC, so keep them for the overflow flag
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1] ^ sub;
    end else if (state == CALC) begin
      ra <= ra >> DIGIT;
      rb <= rb >> DIGIT;
      c <= dsum[DIGIT];
      acc <= acc_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        s <= acc_nx;
        cout <= dsum[DIGIT];
        ovf <= (a_msb == b_msb) && (acc_nx[WIDTH-1] != a_msb);
        zero <= ~|acc_nx;
      end
    end
endmodule
